// File: rtl/demux_ctrl_pkg.sv
// rtl/demux_ctrl_pkg.sv - shared constants and types for the demux dispatcher
package demux_ctrl_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/demux_valid_dec.sv
// rtl/demux_valid_dec.sv - 3-to-8 one-hot valid decoder gated by the FULL state
module demux_valid_dec
  import demux_ctrl_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             full,
  output logic [N_CH-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (full) onehot = N_CH'(1) << sel;
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - one-entry dispatcher steering a word stream onto 8 channels
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             mode,
  input  logic [SEL_W-1:0] fix_sel,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [DW-1:0]    out_data,
  output logic [SEL_W-1:0] sel,
  output logic             drop
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] nxt_ptr;
  logic [CW-1:0]    stall_cnt;
  logic             held_rr;
  logic             handoff;
  logic             drop_now;
  logic             free;
  logic             load;

  assign handoff  = (state == FULL) && out_ready[sel];
  assign drop_now = (TIMEOUT != 0) && (state == FULL) && !out_ready[sel]
                    && (stall_cnt == CNT_LAST);
  assign free     = handoff || drop_now;
  assign in_ready = !rst && ((state == EMPTY) || free);
  assign load     = in_valid && in_ready;

  // Only words that were routed round-robin consume a pointer step, so a
  // mode switch never retroactively moves the pointer.
  assign nxt_ptr = (free && held_rr) ? ptr + SEL_W'(1) : ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      ptr       <= '0;
      sel       <= '0;
      out_data  <= '0;
      stall_cnt <= '0;
      held_rr   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= drop_now;
      ptr  <= nxt_ptr;
      if (load) begin
        state     <= FULL;
        out_data  <= in_data;
        sel       <= (mode == MODE_FIXED) ? fix_sel : nxt_ptr;
        held_rr   <= (mode == MODE_RR);
        stall_cnt <= '0;
      end else if (free) begin
        state     <= EMPTY;
        stall_cnt <= '0;
      end else if (state == FULL) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

  demux_valid_dec u_dec (
    .sel    (sel),
    .full   (state == FULL),
    .onehot (out_valid)
  );

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Registered dispatcher that steers a valid/ready word stream onto one of 8 output channels, sequencing the 1-to-8 demultiplexer select instead of leaving it to static wiring. Each accepted word is held in a one-entry register and offered to a single target channel. The target comes from a round-robin pointer or from a fixed select, depending on mode. A configurable stall timeout drops words aimed at a dead channel, so one channel cannot hang the stream.

## Interface
- `DW`, 8: data width.
- `TIMEOUT`, 16: maximum stall cycles before a held word is dropped; 0 disables dropping.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: upstream may transfer this cycle.
- `in_data` in DW: upstream word.
- `mode` in 1: 0 = round-robin, 1 = fixed.
- `fix_sel` in 3: target channel in fixed mode.
- `out_valid` out 8: one-hot valid; the bit for the target channel is set while a word is held.
- `out_ready` in 8: per-channel ready.
- `out_data` out DW: held word, broadcast to all channels.
- `sel` out 3: target channel of the held word.
- `drop` out 1: one-cycle pulse when a held word is discarded by timeout.

## Operation
- States:
  - EMPTY: holding register free.
  - FULL: one word held.
- Load:
  - Occurs when `in_valid & in_ready`.
  - Captures `in_data`.
  - Target is the current `ptr` (mode 0) or `fix_sel` (mode 1).
  - Clears `stall_cnt`; enters FULL.
- Handoff:
  - Occurs in FULL when `out_ready[sel]` = 1.
  - The word is consumed that cycle.
- Pointer:
  - In mode 0, `ptr` advances by 1 mod 8 on each handoff or drop (wrap 7 -> 0).
  - In mode 1, `ptr` does not change.
- Stall:
  - In FULL without handoff, `stall_cnt` increments.
  - When `stall_cnt` = `TIMEOUT`-1 and the channel is still not ready, the word is discarded: `drop` pulses and the slot frees as if handed off.
- Mode changes and `fix_sel` changes affect only words loaded afterwards. A held word never changes target, and `out_valid` is never withdrawn except by a drop.
- `in_ready` = EMPTY | handoff | drop. It is forced to 0 while `rst` = 1.
- Free and reload in the same cycle:
  - Applies when handoff or drop coincides with a load.
  - The register reloads directly and stays FULL.
  - In mode 0 the new target is the advanced pointer value (old `ptr`+1).
- Handoff has priority over drop on the timeout cycle: when `out_ready[sel]` = 1 there is no `drop`.
- `out_ready` bits of non-target channels are ignored.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `sel` = 0, `drop` = 0.
  - `ptr` = 0, `stall_cnt` = 0, state EMPTY.
  - `in_ready` = 0 during reset and 1 on the first cycle after it.
- Reset mid-operation discards the held word with no `drop` pulse.
- Latency: a word loaded at edge N is visible on `out_valid`/`out_data` from edge N onward, i.e. one register stage.
- Throughput: 1 word per cycle while the targeted channels keep `out_ready` = 1.
- `out_valid`, `out_data`, `sel` and `drop` are registered.
- `in_ready` is combinational from state, `out_ready` and the stall counter.
- A drop occurs exactly `TIMEOUT` cycles after the load when the target is never ready.

## Structure
- Package `demux_ctrl_pkg` holds:
  - `N_CH` = 8 and `SEL_W` = 3.
  - State enum (EMPTY/FULL).
  - Mode constants (`MODE_RR` = 0, `MODE_FIXED` = 1).
- Sub-module `demux_valid_dec`: combinational 3-to-8 one-hot decoder, producing `out_valid` from `sel` gated by the FULL state.
- The stall counter width is derived from `TIMEOUT`, minimum 1 bit.

## Test plan
- Round-robin, all ready: mode 0, all `out_ready` = 8'hFF, 10 back-to-back words 0x00..0x09.
  - Targets are 0,1,...,7,0,1.
  - One word per cycle; `drop` never pulses.
- Fixed mode: `fix_sel` = 5, 3 words.
  - Every `out_valid` = 8'h20.
  - `ptr` stays 0; a switch back to mode 0 sends the next word to channel 0.
- Backpressure: mode 0, channel 2 ready low for 4 cycles, `TIMEOUT` = 16.
  - The word for channel 2 holds with `out_valid` = 8'h04 and `in_ready` = 0.
  - After release, handoff and reload happen in the same cycle, and the next word targets 3.
- Timeout: `TIMEOUT` = 16, `out_ready` = 0 throughout.
  - `drop` pulses 16 cycles after load.
  - A word pending on input loads that cycle and targets `ptr`+1.
- Boundary: `out_ready[sel]` rises exactly on the timeout cycle.
  - Handoff occurs and `drop` stays 0.
- Reset mid-hold: assert `rst` for 1 cycle while FULL.
  - All outputs return to reset values, with no `drop` pulse.
  - The next word targets channel 0.
